// File: rtl/issue_queue_select_scheduler_pkg.sv
// Shared sizing and path types for the issue-queue select scheduler.
package issue_queue_select_scheduler_pkg;

    localparam int ISSUE_QUEUE_ENTRY_NUM      = 16;
    localparam int ISSUE_QUEUE_DISPATCH_WIDTH = 2;
    localparam int ISSUE_QUEUE_ISSUE_WIDTH    = 2;

    typedef logic [$clog2(ISSUE_QUEUE_ENTRY_NUM)-1:0]   IssueQueueIndexPath;
    typedef logic [ISSUE_QUEUE_ENTRY_NUM-1:0]           IssueQueueOneHotPath;
    typedef logic [$clog2(ISSUE_QUEUE_ENTRY_NUM+1)-1:0] IssueQueueCountPath;

endpackage

// File: rtl/issue_queue_select_scheduler_if.sv
// Dispatch, wakeup and issue signals between the pipeline and the issue-queue scheduler.
interface issue_queue_select_scheduler_if
    import issue_queue_select_scheduler_pkg::*;
#(
    parameter int ENTRY_NUM      = ISSUE_QUEUE_ENTRY_NUM,
    parameter int DISPATCH_WIDTH = ISSUE_QUEUE_DISPATCH_WIDTH,
    parameter int ISSUE_WIDTH    = ISSUE_QUEUE_ISSUE_WIDTH
) ();

    localparam int IDX_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = $clog2(ENTRY_NUM + 1);

    logic [DISPATCH_WIDTH-1:0]       dispatchReq;
    logic                            allocatable;
    logic [DISPATCH_WIDTH*IDX_W-1:0] dispatchPtr;
    logic [ENTRY_NUM-1:0]            opReady;
    logic                            issueStall;
    logic [ISSUE_WIDTH-1:0]          selectValid;
    logic [ISSUE_WIDTH*IDX_W-1:0]    selectPtr;
    logic                            flush;
    logic [CNT_W-1:0]                freeCount;

    modport master (
        output dispatchReq, opReady, issueStall, flush,
        input  allocatable, dispatchPtr, selectValid, selectPtr, freeCount
    );

    modport slave (
        input  dispatchReq, opReady, issueStall, flush,
        output allocatable, dispatchPtr, selectValid, selectPtr, freeCount
    );

endinterface

// File: rtl/issue_queue_select_scheduler_age_matrix.sv
// Dispatch-order age matrix giving each entry its rank among eligible entries (0 = oldest).
// Built only when RSD_IQ_AGE_SELECT_EN is defined.
`ifdef RSD_IQ_AGE_SELECT_EN
module iq_age_matrix
    import issue_queue_select_scheduler_pkg::*;
#(
    parameter int ENTRY_NUM      = ISSUE_QUEUE_ENTRY_NUM,
    parameter int DISPATCH_WIDTH = ISSUE_QUEUE_DISPATCH_WIDTH
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          flush,
    input  logic [DISPATCH_WIDTH-1:0][ENTRY_NUM-1:0]      allocate,
    input  logic [ENTRY_NUM-1:0]                          valid,
    input  logic [ENTRY_NUM-1:0]                          eligible,
    output logic [ENTRY_NUM-1:0][$clog2(ENTRY_NUM)-1:0]   rank
);

    localparam int IDX_W = $clog2(ENTRY_NUM);

    // older_q[i][j] set means entry i was dispatched before entry j
    logic [ENTRY_NUM-1:0][ENTRY_NUM-1:0] older_q;
    logic [ENTRY_NUM-1:0][ENTRY_NUM-1:0] older_next;
    logic [ENTRY_NUM-1:0]                lower;

    // Lanes are applied in order so a higher lane's column write overrides a lower lane's row clear.
    always_comb begin
        older_next = older_q;
        lower      = '0;
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            for (int e = 0; e < ENTRY_NUM; e++) begin
                if (allocate[l][e]) begin
                    older_next[e] = '0;
                    for (int x = 0; x < ENTRY_NUM; x++) begin
                        older_next[x][e] = valid[x] | lower[x];
                    end
                end
            end
            lower = lower | allocate[l];
        end
    end

    always_comb begin
        rank = '0;
        for (int e = 0; e < ENTRY_NUM; e++) begin
            for (int x = 0; x < ENTRY_NUM; x++) begin
                if (eligible[x] && older_q[x][e]) begin
                    rank[e] = rank[e] + IDX_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            older_q <= '0;
        end else if (!flush) begin
            older_q <= older_next;
        end
    end

endmodule
`endif

// File: rtl/issue_queue_select_scheduler.sv
// Issue-queue entry allocator and issue select. Default select is lowest-index-first;
// defining RSD_IQ_AGE_SELECT_EN switches to oldest-first through iq_age_matrix.
module issue_queue_select_scheduler
    import issue_queue_select_scheduler_pkg::*;
#(
    parameter int ENTRY_NUM      = ISSUE_QUEUE_ENTRY_NUM,
    parameter int DISPATCH_WIDTH = ISSUE_QUEUE_DISPATCH_WIDTH,
    parameter int ISSUE_WIDTH    = ISSUE_QUEUE_ISSUE_WIDTH
) (
    input logic                          clk,
    input logic                          rst,
    issue_queue_select_scheduler_if.slave bus
);

    localparam int IDX_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = $clog2(ENTRY_NUM + 1);

    // Returns {found, index} of the k-th (0-based) lowest set bit of vec.
    function automatic logic [IDX_W:0] find_kth_one(input logic [ENTRY_NUM-1:0] vec, input int k);
        logic [IDX_W:0] result;
        int             seen;
        result = '0;
        seen   = 0;
        for (int e = 0; e < ENTRY_NUM; e++) begin
            if (vec[e]) begin
                if (seen == k) begin
                    result = {1'b1, IDX_W'(e)};
                end
                seen++;
            end
        end
        return result;
    endfunction

    logic [ENTRY_NUM-1:0]                     valid_q;
    logic [CNT_W-1:0]                         free_count_q;
    logic                                     allocatable;
    logic                                     squash;
    logic [ENTRY_NUM-1:0]                     eligible;
    logic [DISPATCH_WIDTH-1:0][IDX_W:0]       free_hit;
    logic [DISPATCH_WIDTH*IDX_W-1:0]          dispatch_ptr;
    logic [DISPATCH_WIDTH-1:0]                alloc_fire;
    logic [DISPATCH_WIDTH-1:0][ENTRY_NUM-1:0] alloc_onehot;
    logic [ENTRY_NUM-1:0]                     alloc_mask;
    logic [CNT_W-1:0]                         alloc_count;
    logic [ISSUE_WIDTH-1:0][IDX_W:0]          pick;
    logic [ISSUE_WIDTH-1:0]                   select_valid;
    logic [ISSUE_WIDTH*IDX_W-1:0]             select_ptr;
    logic [ENTRY_NUM-1:0]                     issue_mask;
    logic [CNT_W-1:0]                         issue_count;
    int                                       free_count_calc;

    assign squash      = rst | bus.flush;
    assign allocatable = (free_count_q >= CNT_W'(DISPATCH_WIDTH));
    assign eligible    = valid_q & bus.opReady;

    for (genvar i = 0; i < DISPATCH_WIDTH; i++) begin : g_free
        assign free_hit[i] = find_kth_one(~valid_q, i);
    end

    always_comb begin
        dispatch_ptr = '0;
        alloc_fire   = '0;
        alloc_onehot = '0;
        alloc_mask   = '0;
        alloc_count  = '0;
        for (int i = 0; i < DISPATCH_WIDTH; i++) begin
            dispatch_ptr[i*IDX_W +: IDX_W] = free_hit[i][IDX_W-1:0];
            alloc_fire[i] = bus.dispatchReq[i] && allocatable && !bus.flush && free_hit[i][IDX_W];
            alloc_onehot[i][free_hit[i][IDX_W-1:0]] = alloc_fire[i];
            alloc_mask = alloc_mask | alloc_onehot[i];
            if (alloc_fire[i]) begin
                alloc_count = alloc_count + CNT_W'(1);
            end
        end
    end

`ifdef RSD_IQ_AGE_SELECT_EN
    logic [ENTRY_NUM-1:0][IDX_W-1:0] rank;

    iq_age_matrix #(
        .ENTRY_NUM      (ENTRY_NUM),
        .DISPATCH_WIDTH (DISPATCH_WIDTH)
    ) u_age_matrix (
        .clk      (clk),
        .rst      (rst),
        .flush    (bus.flush),
        .allocate (alloc_onehot),
        .valid    (valid_q),
        .eligible (eligible),
        .rank     (rank)
    );

    // Eligible ranks form a dense 0..n-1 sequence, so slot k is simply the entry ranked k.
    always_comb begin
        pick = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            for (int e = 0; e < ENTRY_NUM; e++) begin
                if (eligible[e] && rank[e] == IDX_W'(k)) begin
                    pick[k] = {1'b1, IDX_W'(e)};
                end
            end
        end
    end
`else
    for (genvar k = 0; k < ISSUE_WIDTH; k++) begin : g_pick
        assign pick[k] = find_kth_one(eligible, k);
    end
`endif

    always_comb begin
        select_valid = '0;
        select_ptr   = '0;
        issue_mask   = '0;
        issue_count  = '0;
        for (int k = 0; k < ISSUE_WIDTH; k++) begin
            select_valid[k] = pick[k][IDX_W] & ~squash;
            select_ptr[k*IDX_W +: IDX_W] = pick[k][IDX_W-1:0];
            if (select_valid[k] && !bus.issueStall) begin
                issue_mask[pick[k][IDX_W-1:0]] = 1'b1;
                issue_count = issue_count + CNT_W'(1);
            end
        end
    end

    assign free_count_calc = int'(free_count_q) - int'(alloc_count) + int'(issue_count);

    always_ff @(posedge clk) begin
        if (squash) begin
            valid_q      <= '0;
            free_count_q <= CNT_W'(ENTRY_NUM);
        end else begin
            valid_q      <= (valid_q & ~issue_mask) | alloc_mask;
            free_count_q <= CNT_W'(free_count_calc);
        end
    end

    assign bus.allocatable = allocatable;
    assign bus.dispatchPtr = dispatch_ptr;
    assign bus.selectValid = select_valid;
    assign bus.selectPtr   = select_ptr;
    assign bus.freeCount   = free_count_q;

    // Requests against a full queue are dropped; flag them so the dispatcher bug is visible.
    assert property (@(posedge clk) disable iff (rst) !((|bus.dispatchReq) && !allocatable))
        else $warning("dispatchReq dropped while allocatable is low");

    assert property (@(posedge clk) disable iff (squash)
                     (free_count_calc >= 0) && (free_count_calc <= ENTRY_NUM))
        else $error("free entry count out of range");

endmodule

// File: tb/tb_issue_queue_select_scheduler.sv
// Directed self-checking bench for issue_queue_select_scheduler (either select build).
module tb_issue_queue_select_scheduler;
    import issue_queue_select_scheduler_pkg::*;

    localparam int ENTRY_NUM = 16;
    localparam int DW        = 2;
    localparam int IW        = 2;

`ifdef RSD_IQ_AGE_SELECT_EN
    localparam logic [7:0] SEL_PAIR = {4'd5, 4'd9};
    localparam logic [3:0] SEL_LAST = 4'd3;
`else
    localparam logic [7:0] SEL_PAIR = {4'd5, 4'd3};
    localparam logic [3:0] SEL_LAST = 4'd9;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    issue_queue_select_scheduler_if #(.ENTRY_NUM(ENTRY_NUM), .DISPATCH_WIDTH(DW), .ISSUE_WIDTH(IW)) bus ();

    issue_queue_select_scheduler #(.ENTRY_NUM(ENTRY_NUM), .DISPATCH_WIDTH(DW), .ISSUE_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] req, input logic [15:0] ready, input logic stall, input logic fl);
        bus.dispatchReq = req;
        bus.opReady     = ready;
        bus.issueStall  = stall;
        bus.flush       = fl;
    endtask

    task automatic apply_reset();
        drive(2'b00, 16'h0000, 1'b0, 1'b0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic fill(input int n);
        for (int c = 0; c < n; c++) begin
            drive(2'b11, 16'h0000, 1'b0, 1'b0);
            step();
        end
        drive(2'b00, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        apply_reset();
        drive(2'b00, 16'hFFFF, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.freeCount !== 5'd16) begin errors++; $display("[TB] FAIL reset_free_count: got %0d expected 16", bus.freeCount); end
        checks++; if (bus.allocatable !== 1'b1) begin errors++; $display("[TB] FAIL reset_allocatable: got %b expected 1", bus.allocatable); end
        checks++; if (bus.selectValid !== 2'b00) begin errors++; $display("[TB] FAIL reset_select_valid: got %b expected 00", bus.selectValid); end
        checks++; if (bus.dispatchPtr !== 8'h10) begin errors++; $display("[TB] FAIL reset_dispatch_ptr: got %h expected 10", bus.dispatchPtr); end
        drive(2'b00, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_fill();
        IssueQueueIndexPath lo;
        IssueQueueIndexPath hi;
        IssueQueueCountPath exp_free;
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            drive(2'b11, 16'h0000, 1'b0, 1'b0);
            lo = 4'(2 * c);
            hi = 4'(2 * c + 1);
            @(negedge clk);
            checks++; if (bus.dispatchPtr !== {hi, lo}) begin errors++; $display("[TB] FAIL fill_dispatch_ptr[%0d]: got %h expected %h", c, bus.dispatchPtr, {hi, lo}); end
            step();
            exp_free = 5'(16 - 2 * (c + 1));
            checks++; if (bus.freeCount !== exp_free) begin errors++; $display("[TB] FAIL fill_free_count[%0d]: got %0d expected %0d", c, bus.freeCount, exp_free); end
        end
        checks++; if (bus.allocatable !== 1'b0) begin errors++; $display("[TB] FAIL fill_allocatable: got %b expected 0", bus.allocatable); end
        drive(2'b11, 16'h0000, 1'b0, 1'b0);
        step();
        checks++; if (bus.freeCount !== 5'd0) begin errors++; $display("[TB] FAIL overflow_free_count: got %0d expected 0", bus.freeCount); end
        drive(2'b00, 16'hFFFF, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (bus.selectValid !== 2'b11) begin errors++; $display("[TB] FAIL full_select_valid: got %b expected 11", bus.selectValid); end
        checks++; if (bus.selectPtr !== 8'h10) begin errors++; $display("[TB] FAIL full_select_ptr: got %h expected 10", bus.selectPtr); end
        drive(2'b00, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_select();
        apply_reset();
        fill(5);
        drive(2'b00, 16'h0020, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.selectValid !== 2'b01 || bus.selectPtr[3:0] !== 4'd5) begin errors++; $display("[TB] FAIL sel_free5: got %b/%h expected 01/5", bus.selectValid, bus.selectPtr[3:0]); end
        step();
        checks++; if (bus.freeCount !== 5'd7) begin errors++; $display("[TB] FAIL sel_free5_count: got %0d expected 7", bus.freeCount); end
        drive(2'b01, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.dispatchPtr[3:0] !== 4'd5) begin errors++; $display("[TB] FAIL sel_redispatch5: got %h expected 5", bus.dispatchPtr[3:0]); end
        step();
        drive(2'b00, 16'h0008, 1'b0, 1'b0);
        step();
        checks++; if (bus.freeCount !== 5'd7) begin errors++; $display("[TB] FAIL sel_free3_count: got %0d expected 7", bus.freeCount); end
        drive(2'b01, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.dispatchPtr[3:0] !== 4'd3) begin errors++; $display("[TB] FAIL sel_redispatch3: got %h expected 3", bus.dispatchPtr[3:0]); end
        step();
        drive(2'b00, 16'h0228, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.selectValid !== 2'b11 || bus.selectPtr !== SEL_PAIR) begin errors++; $display("[TB] FAIL sel_pair: got %b/%h expected 11/%h", bus.selectValid, bus.selectPtr, SEL_PAIR); end
        step();
        checks++; if (bus.freeCount !== 5'd8) begin errors++; $display("[TB] FAIL sel_pair_count: got %0d expected 8", bus.freeCount); end
        @(negedge clk);
        checks++; if (bus.selectValid !== 2'b01 || bus.selectPtr[3:0] !== SEL_LAST) begin errors++; $display("[TB] FAIL sel_last: got %b/%h expected 01/%h", bus.selectValid, bus.selectPtr[3:0], SEL_LAST); end
        step();
        checks++; if (bus.freeCount !== 5'd9) begin errors++; $display("[TB] FAIL sel_last_count: got %0d expected 9", bus.freeCount); end
        checks++; if (bus.selectValid !== 2'b00) begin errors++; $display("[TB] FAIL sel_drained: got %b expected 00", bus.selectValid); end
        drive(2'b00, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        apply_reset();
        fill(3);
        for (int c = 0; c < 3; c++) begin
            drive(2'b00, 16'h0014, 1'b1, 1'b0);
            @(negedge clk);
            checks++; if (bus.selectValid !== 2'b11 || bus.selectPtr !== 8'h42) begin errors++; $display("[TB] FAIL stall_grants[%0d]: got %b/%h expected 11/42", c, bus.selectValid, bus.selectPtr); end
            step();
            checks++; if (bus.freeCount !== 5'd10) begin errors++; $display("[TB] FAIL stall_free_count[%0d]: got %0d expected 10", c, bus.freeCount); end
        end
        drive(2'b00, 16'h0014, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.selectValid !== 2'b11 || bus.selectPtr !== 8'h42) begin errors++; $display("[TB] FAIL stall_release_grants: got %b/%h expected 11/42", bus.selectValid, bus.selectPtr); end
        step();
        checks++; if (bus.freeCount !== 5'd12) begin errors++; $display("[TB] FAIL stall_release_count: got %0d expected 12", bus.freeCount); end
        @(negedge clk);
        checks++; if (bus.selectValid !== 2'b00) begin errors++; $display("[TB] FAIL stall_cleared: got %b expected 00", bus.selectValid); end
        drive(2'b00, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        apply_reset();
        fill(4);
        drive(2'b00, 16'h0003, 1'b0, 1'b0);
        step();
        checks++; if (bus.freeCount !== 5'd10) begin errors++; $display("[TB] FAIL flush_setup_count: got %0d expected 10", bus.freeCount); end
        drive(2'b11, 16'h0080, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.selectValid !== 2'b01 || bus.selectPtr[3:0] !== 4'd7) begin errors++; $display("[TB] FAIL flush_pre_grant: got %b/%h expected 01/7", bus.selectValid, bus.selectPtr[3:0]); end
        checks++; if (bus.dispatchPtr !== 8'h10) begin errors++; $display("[TB] FAIL flush_dispatch_ptr: got %h expected 10", bus.dispatchPtr); end
        bus.flush = 1'b1;
        #1;
        checks++; if (bus.selectValid !== 2'b00) begin errors++; $display("[TB] FAIL flush_select_forced: got %b expected 00", bus.selectValid); end
        step();
        drive(2'b00, 16'hFFFF, 1'b0, 1'b0);
        checks++; if (bus.freeCount !== 5'd16 || bus.allocatable !== 1'b1) begin errors++; $display("[TB] FAIL flush_state: got %0d/%b expected 16/1", bus.freeCount, bus.allocatable); end
        @(negedge clk);
        checks++; if (bus.selectValid !== 2'b00) begin errors++; $display("[TB] FAIL flush_valid_cleared: got %b expected 00", bus.selectValid); end
        drive(2'b00, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_full_queue();
        apply_reset();
        fill(8);
        drive(2'b01, 16'h0020, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.allocatable !== 1'b0) begin errors++; $display("[TB] FAIL full_alloc_low: got %b expected 0", bus.allocatable); end
        checks++; if (bus.selectValid !== 2'b01 || bus.selectPtr[3:0] !== 4'd5) begin errors++; $display("[TB] FAIL full_issue5: got %b/%h expected 01/5", bus.selectValid, bus.selectPtr[3:0]); end
        step();
        checks++; if (bus.freeCount !== 5'd1 || bus.allocatable !== 1'b0) begin errors++; $display("[TB] FAIL full_after_issue: got %0d/%b expected 1/0", bus.freeCount, bus.allocatable); end
        drive(2'b01, 16'h0000, 1'b0, 1'b0);
        step();
        checks++; if (bus.freeCount !== 5'd1) begin errors++; $display("[TB] FAIL full_ignored_dispatch: got %0d expected 1", bus.freeCount); end
        drive(2'b00, 16'h0040, 1'b0, 1'b0);
        step();
        checks++; if (bus.freeCount !== 5'd2 || bus.allocatable !== 1'b1) begin errors++; $display("[TB] FAIL full_two_free: got %0d/%b expected 2/1", bus.freeCount, bus.allocatable); end
        drive(2'b01, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.dispatchPtr !== 8'h65) begin errors++; $display("[TB] FAIL full_dispatch_ptr: got %h expected 65", bus.dispatchPtr); end
        step();
        checks++; if (bus.freeCount !== 5'd1) begin errors++; $display("[TB] FAIL full_dispatch_ok: got %0d expected 1", bus.freeCount); end
        drive(2'b00, 16'h0060, 1'b1, 1'b0);
        @(negedge clk);
        checks++; if (bus.selectValid !== 2'b01 || bus.selectPtr[3:0] !== 4'd5) begin errors++; $display("[TB] FAIL full_entry5_valid: got %b/%h expected 01/5", bus.selectValid, bus.selectPtr[3:0]); end
        drive(2'b00, 16'h0000, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        apply_reset();
        fill(3);
        drive(2'b00, 16'hFFFF, 1'b0, 1'b0);
        @(negedge clk);
        checks++; if (bus.selectValid !== 2'b11 || bus.selectPtr !== 8'h10) begin errors++; $display("[TB] FAIL rstmid_pre_grant: got %b/%h expected 11/10", bus.selectValid, bus.selectPtr); end
        rst = 1'b1;
        #1;
        checks++; if (bus.selectValid !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_select_forced: got %b expected 00", bus.selectValid); end
        step();
        rst = 1'b0;
        checks++; if (bus.freeCount !== 5'd16) begin errors++; $display("[TB] FAIL rstmid_free_count: got %0d expected 16", bus.freeCount); end
        @(negedge clk);
        checks++; if (bus.selectValid !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_valid_cleared: got %b expected 00", bus.selectValid); end
        drive(2'b00, 16'h0000, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        drive(2'b00, 16'h0000, 1'b0, 1'b0);
        test_reset();
        test_fill();
        test_select();
        test_stall();
        test_flush();
        test_full_queue();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
